// File: rtl/aes_disp_pkg.sv
// aes_disp_pkg: shared sizing constants and pair-index type for the AES lane dispatcher.
package aes_disp_pkg;
    localparam int NUM_PAIRS = 12;
    localparam int LANE_W = 4;
    localparam int TEXT_W = 256;
    typedef logic [LANE_W-1:0] pair_idx_t;
endpackage

// File: rtl/aes_disp_order_fifo.sv
// aes_disp_order_fifo: pair-index FIFO recording dispatch order; push and pop may coincide.
module aes_disp_order_fifo #(
    parameter int DEPTH = aes_disp_pkg::NUM_PAIRS,
    parameter int W = aes_disp_pkg::LANE_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               push_idx_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    always_comb begin
        wr_d = push_i ? wrap_inc(wr_q) : wr_q;
        rd_d = pop_i ? wrap_inc(rd_q) : rd_q;
        cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= push_idx_i;
    end
    assign head_o = mem_q[rd_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/aes_lane_dispatcher.sv
// aes_lane_dispatcher: round-robin feeder for paired AES cores with an in-order completion tag stream.
// Define AES_DISP_STATS_EN to add the stat_words/stat_stall counters.
module aes_lane_dispatcher #(
    parameter int NUM_PAIRS = aes_disp_pkg::NUM_PAIRS,
    parameter int LANE_W = aes_disp_pkg::LANE_W
) (
    input  logic                              clk,
    input  logic                              rst,
`ifdef AES_DISP_STATS_EN
    output logic [31:0]                       stat_words,
    output logic [31:0]                       stat_stall,
`endif
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [aes_disp_pkg::TEXT_W-1:0]   in_data,
    output logic [aes_disp_pkg::TEXT_W-1:0]   text_in,
    output logic [NUM_PAIRS-1:0]              kld,
    input  logic [2*NUM_PAIRS-1:0]            done,
    output logic                              ord_valid,
    input  logic                              ord_ready,
    output logic [LANE_W-1:0]                 ord_lane
);
    import aes_disp_pkg::*;
    localparam int CW = $clog2(NUM_PAIRS + 1);
    logic [TEXT_W-1:0] text_q, text_d;
    logic [NUM_PAIRS-1:0] kld_q, kld_d, busy_q, busy_d;
    logic [2*NUM_PAIRS-1:0] seen_q, seen_d;
    logic [LANE_W-1:0] rr_q, rr_d, sel, head;
    logic [CW-1:0] cnt;
    logic accept, pop;
    // Walk downward so the free pair nearest rr_q wins.
    always_comb begin
        sel = '0;
        for (int k = NUM_PAIRS - 1; k >= 0; k--)
            if (!busy_q[LANE_W'((int'(rr_q) + k) % NUM_PAIRS)]) sel = LANE_W'((int'(rr_q) + k) % NUM_PAIRS);
    end
    assign in_ready = ~&busy_q;
    assign accept = in_valid && in_ready;
    assign ord_valid = (cnt != '0) && seen_q[{head, 1'b0}] && seen_q[{head, 1'b1}];
    assign ord_lane = (cnt != '0) ? head : '0;
    assign pop = ord_valid && ord_ready;
    always_comb begin
        busy_d = busy_q;
        seen_d = seen_q;
        for (int p = 0; p < NUM_PAIRS; p++)
            seen_d[2*p +: 2] = seen_q[2*p +: 2] | (done[2*p +: 2] & {2{busy_q[p]}});
        if (accept) busy_d[sel] = 1'b1;
        // Pop clears after the done merge so a same-cycle done cannot survive it.
        if (pop) begin
            busy_d[head] = 1'b0;
            seen_d[{head, 1'b0}] = 1'b0;
            seen_d[{head, 1'b1}] = 1'b0;
        end
        kld_d = accept ? (NUM_PAIRS'(1) << sel) : '0;
        text_d = accept ? in_data : text_q;
        rr_d = accept ? ((sel == LANE_W'(NUM_PAIRS - 1)) ? '0 : sel + 1'b1) : rr_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            text_q <= '0;
            kld_q <= '0;
            busy_q <= '0;
            seen_q <= '0;
            rr_q <= '0;
        end else begin
            text_q <= text_d;
            kld_q <= kld_d;
            busy_q <= busy_d;
            seen_q <= seen_d;
            rr_q <= rr_d;
        end
    end
    assign text_in = text_q;
    assign kld = kld_q;
    aes_disp_order_fifo #(.DEPTH(NUM_PAIRS), .W(LANE_W)) u_order (
        .clk        (clk),
        .rst        (rst),
        .push_i     (accept),
        .push_idx_i (sel),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (cnt)
    );
`ifdef AES_DISP_STATS_EN
    logic [31:0] words_q, stall_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            words_q <= '0;
            stall_q <= '0;
        end else begin
            words_q <= words_q + 32'(accept);
            stall_q <= stall_q + 32'(in_valid && !in_ready);
        end
    end
    assign stat_words = words_q;
    assign stat_stall = stall_q;
`endif
endmodule
